// File: rtl/ysyx_24080014_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter and sequencer for the shared memory port.
// Build option: YSYX_24080014_ARB_RR_EN selects round-robin, else LSU-first.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   ifu_req_*        : IFU read request handshake (addr only)
//   ifu_rsp_valid/rdata : one-cycle fetch response
//   lsu_req_*        : LSU load/store request handshake
//   lsu_rsp_valid/rdata : one-cycle load/store response (rdata 0 for stores)
//   mem_req_*        : registered command toward memory, valid/ready
//   mem_rsp_valid/rdata : memory read data or write ack
module ysyx_24080014_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  output logic        mem_wen,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        lsu;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } cmd_t;

  state_t      state;
  cmd_t        cmd;
  cmd_t        nxt_cmd;
  logic [31:0] rsp_q;
  logic [31:0] cap_data;
  logic        req_v_q;
  logic        ifu_rv_q;
  logic        lsu_rv_q;
  logic        grant_ifu;
  logic        grant_lsu;
  logic        idle;
  logic        accept;

`ifdef YSYX_24080014_ARB_RR_EN
  logic        last_lsu;

  // On contention the master that did not win last time goes first.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    priority case (1'b1)
      lsu_req_valid && (!ifu_req_valid || !last_lsu):
        grant_lsu = 1'b1;
      ifu_req_valid:
        grant_ifu = 1'b1;
      default: ;
    endcase
  end
`else
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    priority case (1'b1)
      lsu_req_valid: grant_lsu = 1'b1;
      ifu_req_valid: grant_ifu = 1'b1;
      default: ;
    endcase
  end
`endif

  assign idle   = (state == IDLE) && !rst;
  assign accept = idle && (grant_ifu || grant_lsu);

  assign ifu_req_ready = idle && grant_ifu;
  assign lsu_req_ready = idle && grant_lsu;

  // Fetches carry no write fields.
  always_comb begin
    nxt_cmd = '0;
    if (grant_lsu) begin
      nxt_cmd.lsu   = 1'b1;
      nxt_cmd.wen   = lsu_wen;
      nxt_cmd.addr  = lsu_addr;
      nxt_cmd.wdata = lsu_wdata;
      nxt_cmd.wmask = lsu_wmask;
    end else begin
      nxt_cmd.addr  = ifu_addr;
    end
  end

  // A store ack carries no data; keep the response word clean.
  assign cap_data = cmd.wen ? 32'h0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd      <= '0;
      rsp_q    <= 32'h0;
      req_v_q  <= 1'b0;
      ifu_rv_q <= 1'b0;
      lsu_rv_q <= 1'b0;
`ifdef YSYX_24080014_ARB_RR_EN
      last_lsu <= 1'b0;
`endif
    end else begin
      ifu_rv_q <= 1'b0;
      lsu_rv_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cmd     <= nxt_cmd;
            req_v_q <= 1'b1;
            state   <= REQ;
`ifdef YSYX_24080014_ARB_RR_EN
            last_lsu <= grant_lsu;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            req_v_q <= 1'b0;
            if (mem_rsp_valid) begin
              rsp_q    <= cap_data;
              ifu_rv_q <= !cmd.lsu;
              lsu_rv_q <= cmd.lsu;
              state    <= RESP;
            end else begin
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rsp_q    <= cap_data;
            ifu_rv_q <= !cmd.lsu;
            lsu_rv_q <= cmd.lsu;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid = req_v_q;
  assign mem_wen       = cmd.wen;
  assign mem_addr      = cmd.addr;
  assign mem_wdata     = cmd.wdata;
  assign mem_wmask     = cmd.wmask;

  assign ifu_rsp_valid = ifu_rv_q;
  assign lsu_rsp_valid = lsu_rv_q;
  assign ifu_rdata     = rsp_q;
  assign lsu_rdata     = rsp_q;

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Bench for ysyx_24080014_mem_arbiter: directed + random transactions
// checked against a transaction-level latency/arbitration model.
module tb_ysyx_24080014_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_wen;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  int n_asrt = 0;
  int n_fail = 0;

`ifdef YSYX_24080014_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  bit          last_was_lsu;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  ysyx_24080014_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_wen       (lsu_wen),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_wen       (mem_wen),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] ev
  );
    n_asrt++;
    assert (obs === ev) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, ev);
    end
  endtask

  task automatic txn(
    input bit          ifu_on,
    input bit          lsu_on,
    input bit          wen,
    input logic [31:0] iaddr,
    input logic [31:0] laddr,
    input logic [31:0] wdata,
    input logic [7:0]  wmask,
    input int          rw,
    input int          sw,
    input logic [31:0] rdata
  );
    bit          win;
    int          lat;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    if (ifu_on && lsu_on) win = RR ? !last_was_lsu : 1'b1;
    else win = lsu_on;
    lat      = 2 + rw + sw;
    exp_rd   = (win && wen) ? 32'h0 : rdata;
    exp_addr = win ? laddr : iaddr;

    ifu_req_valid = ifu_on;
    ifu_addr      = iaddr;
    lsu_req_valid = lsu_on;
    lsu_wen       = wen;
    lsu_addr      = laddr;
    lsu_wdata     = wdata;
    lsu_wmask     = wmask;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk("ifu_ready", ifu_req_ready, !win);
    chk("lsu_ready", lsu_req_ready, win);
    last_was_lsu = win;

    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (win) lsu_req_valid = 1'b0;
      else ifu_req_valid = 1'b0;
      chk("mem_req_valid", mem_req_valid, (k <= 1 + rw));
      if (k <= 1 + rw) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wen", mem_wen, win && wen);
        chk("mem_wmask", mem_wmask, win ? wmask : 8'h0);
        if (win) chk("mem_wdata", mem_wdata, wdata);
      end
      chk("ifu_rsp_valid", ifu_rsp_valid, (!win && k == lat));
      chk("lsu_rsp_valid", lsu_rsp_valid, (win && k == lat));
      if (k <= lat) begin
        chk("ifu_ready_busy", ifu_req_ready, 1'b0);
        chk("lsu_ready_busy", lsu_req_ready, 1'b0);
      end
      if (k == lat) begin
        if (win) chk("lsu_rdata", lsu_rdata, exp_rd);
        else chk("ifu_rdata", ifu_rdata, exp_rd);
      end
      mem_req_ready = (k == 1 + rw);
      mem_rsp_valid = (k == 1 + rw + sw);
      mem_rdata     = mem_rsp_valid ? rdata : $urandom;
      if (k == lat + 1) begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
      end
    end
    last_rd = exp_rd;
  endtask

  initial begin
    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_addr      = 32'h0;
    lsu_wen       = 1'b0;
    lsu_addr      = 32'h0;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 8'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    last_was_lsu  = 1'b0;
    last_rd       = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_ifu_ready", ifu_req_ready, 1'b0);
    chk("rst_lsu_ready", lsu_req_ready, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_mem_wen", mem_wen, 1'b0);
    chk("rst_mem_wmask", mem_wmask, 8'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_ifu_rsp", ifu_rsp_valid, 1'b0);
    chk("rst_lsu_rsp", lsu_rsp_valid, 1'b0);
    chk("rst_ifu_rdata", ifu_rdata, 32'h0);
    chk("rst_lsu_rdata", lsu_rdata, 32'h0);
    rst           = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    txn(1, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 8'h0, 0, 0, 32'h0000_0413);
    txn(0, 1, 1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 3, 0,
        32'h5555_AAAA);
    for (int i = 0; i < 4; i++)
      txn(1, 1, 0, 32'h8000_0100 + 32'(i * 4), 32'h8000_2000 + 32'(i * 4),
          32'h0, 8'h0, 0, 0, $urandom);
    txn(0, 1, 0, 32'h0, 32'h8000_3000, 32'h0, 8'h0, 0, 5, 32'h0000_00FF);

    txn(1, 0, 0, 32'h8000_0040, 32'h0, 32'h0, 8'h0, 1, 1, 32'h1111_2222);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("spur_mem_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    chk("spur_ifu_rsp", ifu_rsp_valid, 1'b0);
    chk("spur_lsu_rsp", lsu_rsp_valid, 1'b0);
    chk("spur_ifu_rdata", ifu_rdata, last_rd);
    chk("spur_lsu_rdata", lsu_rdata, last_rd);

    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b0;
    lsu_addr      = 32'h8000_4000;
    @(negedge clk);
    lsu_req_valid = 1'b0;
    chk("rw_mem_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    last_was_lsu  = 1'b0;
    chk("rw_mem_valid_rst", mem_req_valid, 1'b0);
    chk("rw_lsu_rsp_rst", lsu_rsp_valid, 1'b0);
    chk("rw_lsu_rdata_rst", lsu_rdata, 32'h0);
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("rw_lsu_rsp_late", lsu_rsp_valid, 1'b0);
      chk("rw_ifu_rsp_late", ifu_rsp_valid, 1'b0);
      chk("rw_lsu_rdata_late", lsu_rdata, 32'h0);
    end
    txn(1, 0, 0, 32'h8000_0080, 32'h0, 32'h0, 8'h0, 0, 0, 32'h0000_0013);

    for (int i = 0; i < 30; i++) begin
      bit a;
      bit b;
      a = 1'($urandom);
      b = 1'($urandom);
      if (!a && !b) a = 1'b1;
      txn(a, b, 1'($urandom), $urandom, $urandom, $urandom, 8'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
